// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states and
// op-class helpers, also used by the E-stage control decode.
package mult_div_unit_pkg;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8
   } mdu_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mdu_state_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   function automatic logic is_mul_op(mdu_op_e op);
      return (op == OP_MULT) || (op == OP_MULTU);
   endfunction

   function automatic logic is_div_op(mdu_op_e op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_md_op(mdu_op_e op);
      return is_mul_op(op) || is_div_op(op);
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Bus between the E stage / hazard unit and the multiply/divide unit.
// Handshake: start is high in the one cycle a mult/div is accepted; it can only
// be high while busy is low, and busy stays high until HI/LO have been committed.
interface mult_div_unit_if;
   import mult_div_unit_pkg::*;

   mdu_op_e     op;
   logic [31:0] A;
   logic [31:0] B;
   logic        start;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MDU_out;
   mdu_state_e  state;

   modport master (
      output op, A, B,
      input  start, busy, HI, LO, MDU_out, state
   );

   modport slave (
      input  op, A, B,
      output start, busy, HI, LO, MDU_out, state
   );

endinterface

// File: rtl/mult_div_unit_arith.sv
// Combinational 64-bit multiply/divide result {hi, lo} for the current op and
// operands, plus a flag marking a divide by zero.
module mult_div_unit_arith
   import mult_div_unit_pkg::*;
(
   input  mdu_op_e     op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] result,
   output logic        div_by_zero
);

   logic        sdiv;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] num;
   logic [31:0] den;
   logic [31:0] den_safe;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quot;
   logic [31:0] rem;
   logic [63:0] prod_s;
   logic [63:0] prod_u;

   // Signed divide works on magnitudes so that 0x80000000 / -1 wraps instead
   // of overflowing a signed native divide.
   assign sdiv     = (op == OP_DIV);
   assign a_neg    = sdiv && a[31];
   assign b_neg    = sdiv && b[31];
   assign num      = a_neg ? (~a + 32'd1) : a;
   assign den      = b_neg ? (~b + 32'd1) : b;
   assign den_safe = (b == 32'd0) ? 32'd1 : den;
   assign q_mag    = num / den_safe;
   assign r_mag    = num % den_safe;
   assign quot     = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
   assign rem      = a_neg ? (~r_mag + 32'd1) : r_mag;

   assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign prod_u = {32'd0, a} * {32'd0, b};

   assign div_by_zero = is_div_op(op) && (b == 32'd0);

   always_comb begin
      result = 64'd0;
      case (op)
         OP_MULT:  result = prod_s;
         OP_MULTU: result = prod_u;
         OP_DIV,
         OP_DIVU:  result = {rem, quot};
         default:  result = 64'd0;
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs mult/div for a fixed number of
// busy cycles and commits the precomputed result when the countdown expires.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   mult_div_unit_if.slave    bus
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   mdu_state_e  state;
   logic [CW-1:0] count;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [31:0] hi_tmp;
   logic [31:0] lo_tmp;
   logic        commit_en;
   logic        busy;
   logic        start;
   logic [63:0] arith_result;
   logic        arith_div0;

   mult_div_unit_arith u_arith (
      .op          (bus.op),
      .a           (bus.A),
      .b           (bus.B),
      .result      (arith_result),
      .div_by_zero (arith_div0)
   );

   assign busy  = (state == BUSY);
   assign start = is_md_op(bus.op) && !busy && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         count     <= '0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         hi_tmp    <= 32'd0;
         lo_tmp    <= 32'd0;
         commit_en <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  hi_tmp    <= arith_result[63:32];
                  lo_tmp    <= arith_result[31:0];
                  commit_en <= !arith_div0;
                  count     <= is_mul_op(bus.op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                  state     <= BUSY;
               end else if (bus.op == OP_MTHI) begin
                  hi_q <= bus.A;
               end else if (bus.op == OP_MTLO) begin
                  lo_q <= bus.A;
               end
            end
            BUSY: begin
               // Anything presented on op while busy is deliberately ignored.
               if (count == CW'(1)) begin
                  state <= IDLE;
                  count <= '0;
                  if (commit_en) begin
                     hi_q <= hi_tmp;
                     lo_q <= lo_tmp;
                  end
               end else begin
                  count <= count - CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               count <= '0;
            end
         endcase
      end
   end

   assign bus.start   = start;
   assign bus.busy    = busy;
   assign bus.HI      = hi_q;
   assign bus.LO      = lo_q;
   assign bus.state   = state;
   assign bus.MDU_out = (bus.op == OP_MFHI) ? hi_q :
                        (bus.op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: vector table, hand-built corner sequences and a
// randomized run checked against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic [63:0] exp_q[$];
   logic [31:0] cur_hi;
   logic [31:0] cur_lo;

   mult_div_unit_if mif ();

   mult_div_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (mif)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      mdu_op_e     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } vec_t;

   vec_t vecs[7];

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference HI/LO after an op, from plain 64-bit arithmetic.
   function automatic logic [63:0] model(input mdu_op_e op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
      longint          sa, sb, sq, sr;
      longint unsigned ua, ub;
      logic [63:0]     r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = cur;
      case (op)
         OP_MULT:  r = 64'(sa * sb);
         OP_MULTU: r = ua * ub;
         OP_DIV:   if (b != 0) begin
                      sq = sa / sb;
                      sr = sa % sb;
                      r  = {sr[31:0], sq[31:0]};
                   end
         OP_DIVU:  if (b != 0) r = {32'(ua % ub), 32'(ua / ub)};
         OP_MTHI:  r = {a, cur[31:0]};
         OP_MTLO:  r = {cur[63:32], a};
         default:  r = cur;
      endcase
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   // Issues a mult/div in the current cycle and returns the number of busy cycles.
   task automatic run_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                         output int n);
      mif.op = op;
      mif.A  = a;
      mif.B  = b;
      #1;
      check("start_on_issue", {31'd0, mif.start}, 32'd1);
      @(posedge clk);
      #1;
      mif.op = OP_NONE;
      n = 0;
      while (mif.busy === 1'b1 && n < 40) begin
         n++;
         tick();
      end
   endtask

   task automatic one_cycle_op(input mdu_op_e op, input logic [31:0] a);
      mif.op = op;
      mif.A  = a;
      tick();
      mif.op = OP_NONE;
   endtask

   // ---------------- main test ----------------
   initial begin
      int n;
      logic [63:0] exp;
      mdu_op_e rop;
      logic [31:0] ra, rb;

      checks = 0;
      errors = 0;
      vecs[0] = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
      vecs[1] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10};
      vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vecs[3] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10};
      vecs[4] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
      vecs[5] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
      vecs[6] = '{OP_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 5};

      // Reset: op held at MULT to show start stays low under reset.
      reset  = 1'b1;
      mif.op = OP_MULT;
      mif.A  = 32'd1;
      mif.B  = 32'd1;
      tick();
      tick();
      check("rst_start", {31'd0, mif.start}, 32'd0);
      check("rst_busy",  {31'd0, mif.busy},  32'd0);
      check("rst_hi",    mif.HI, 32'd0);
      check("rst_lo",    mif.LO, 32'd0);
      reset  = 1'b0;
      mif.op = OP_NONE;
      tick();
      check("idle_mdu_out", mif.MDU_out, 32'd0);

      // Vector table.
      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
         check($sformatf("vec%0d_cycles", i), 32'(n), 32'(vecs[i].cyc));
         check($sformatf("vec%0d_hi", i), mif.HI, vecs[i].hi);
         check($sformatf("vec%0d_lo", i), mif.LO, vecs[i].lo);
         check($sformatf("vec%0d_busy", i), {31'd0, mif.busy}, 32'd0);
      end

      // divu then reads of the committed result.
      run_op(OP_DIVU, 32'd100, 32'd7, n);
      mif.op = OP_MFLO;
      #1;
      check("mflo_read", mif.MDU_out, 32'd14);
      mif.op = OP_MFHI;
      #1;
      check("mfhi_read", mif.MDU_out, 32'd2);
      mif.op = OP_NONE;
      tick();

      // mthi/mtlo, then divide by zero keeps HI/LO; mthi during busy is ignored.
      one_cycle_op(OP_MTHI, 32'h1234);
      one_cycle_op(OP_MTLO, 32'h5678);
      check("mthi_hi", mif.HI, 32'h1234);
      check("mtlo_lo", mif.LO, 32'h5678);
      mif.op = OP_DIV;
      mif.A  = 32'd55;
      mif.B  = 32'd0;
      #1;
      check("div0_start", {31'd0, mif.start}, 32'd1);
      tick();
      mif.op = OP_MTHI;
      mif.A  = 32'h0BAD;
      #1;
      check("busy_mthi_start", {31'd0, mif.start}, 32'd0);
      n = 0;
      while (mif.busy === 1'b1 && n < 40) begin
         n++;
         tick();
         mif.op = OP_NONE;
      end
      check("div0_cycles", 32'(n), 32'd10);
      check("div0_hi", mif.HI, 32'h1234);
      check("div0_lo", mif.LO, 32'h5678);

      // Reads and a second mult while busy, then back-to-back issue in cycle 6.
      one_cycle_op(OP_MTHI, 32'hAAAA);
      one_cycle_op(OP_MTLO, 32'hBBBB);
      mif.op = OP_MULT; mif.A = 32'd5; mif.B = 32'd6;
      #1;
      check("c0_start", {31'd0, mif.start}, 32'd1);
      tick();
      mif.op = OP_MULT; mif.A = 32'd9; mif.B = 32'd9;
      #1;
      check("c1_busy_start", {31'd0, mif.start}, 32'd0);
      check("c1_busy", {31'd0, mif.busy}, 32'd1);
      tick();
      mif.op = OP_NONE;
      tick();
      mif.op = OP_MFHI;
      #1;
      check("c3_mfhi_old", mif.MDU_out, 32'hAAAA);
      mif.op = OP_MFLO;
      #1;
      check("c3_mflo_old", mif.MDU_out, 32'hBBBB);
      mif.op = OP_NONE;
      tick();
      tick();
      check("c5_busy", {31'd0, mif.busy}, 32'd1);
      tick();
      check("c6_busy", {31'd0, mif.busy}, 32'd0);
      check("c6_hi", mif.HI, 32'd0);
      check("c6_lo", mif.LO, 32'd30);
      run_op(OP_MULT, 32'd7, 32'd8, n);
      check("b2b_cycles", 32'(n), 32'd5);
      check("b2b_lo", mif.LO, 32'd56);

      // Reset in cycle 4 of a div abandons it.
      mif.op = OP_DIV; mif.A = 32'd1000; mif.B = 32'd3;
      tick();
      mif.op = OP_NONE;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_mid_busy", {31'd0, mif.busy}, 32'd0);
      check("rst_mid_hi", mif.HI, 32'd0);
      check("rst_mid_lo", mif.LO, 32'd0);
      repeat (15) tick();
      check("rst_after_hi", mif.HI, 32'd0);
      check("rst_after_lo", mif.LO, 32'd0);
      check("rst_after_busy", {31'd0, mif.busy}, 32'd0);

      // Randomized ops against the model.
      cur_hi = 32'd0;
      cur_lo = 32'd0;
      for (int it = 0; it < 60; it++) begin
         rop = mdu_op_e'(4'($urandom_range(1, 8)));
         ra  = $urandom;
         rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
         if (is_md_op(rop)) begin
            exp_q.push_back(model(rop, ra, rb, {cur_hi, cur_lo}));
            run_op(rop, ra, rb, n);
            check("rnd_cycles", 32'(n), is_mul_op(rop) ? 32'd5 : 32'd10);
            exp = exp_q.pop_front();
            check($sformatf("rnd%0d_op%0d_hi", it, rop), mif.HI, exp[63:32]);
            check($sformatf("rnd%0d_op%0d_lo", it, rop), mif.LO, exp[31:0]);
            {cur_hi, cur_lo} = exp;
         end else if (rop == OP_MTHI || rop == OP_MTLO) begin
            exp = model(rop, ra, rb, {cur_hi, cur_lo});
            one_cycle_op(rop, ra);
            check("rnd_mt_hi", mif.HI, exp[63:32]);
            check("rnd_mt_lo", mif.LO, exp[31:0]);
            {cur_hi, cur_lo} = exp;
         end else begin
            mif.op = rop;
            #1;
            check("rnd_mf", mif.MDU_out, (rop == OP_MFHI) ? cur_hi : cur_lo);
            mif.op = OP_NONE;
            tick();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule
